// File: rtl/tdm_demux.sv
// tdm_demux -- receive end of the 3-stream TDM link.
// Splits the multiplexed word stream back into DS1/DS2/DS3. A frame is six
// clock cycles divided into `mode` equal slots (6, 3 or 2 cycles long),
// ordered DS1, DS2, DS3. One word is captured per slot at SAMPLE_OFFSET,
// which is clamped to the last cycle of the slot. Each captured word appears
// one clock later on its dsN output together with a one-cycle dsN_valid.
//
// Optional feature macro: DEMUX_LOCK_CHECK_EN
//   defined   : frame_sync must arrive exactly at each frame wrap. An early
//               sync pulses sync_err, suppresses that cycle's capture and
//               restarts the frame. A missing sync pulses sync_err and drops
//               back to IDLE.
//   undefined : frame_sync in RUN is a plain resync, a missing sync is
//               tolerated (free-run) and sync_err is tied low.
//
// Ports
//   clk        in   1       single clock, posedge
//   rst        in   1       asynchronous, active-high reset
//   mode       in   2       1=DS1, 2=DS1/DS2, 3=DS1/DS2/DS3, 0=illegal
//   frame_sync in   1       high on cycle 0 of a frame
//   mux_data   in   DATA_W  multiplexed word, held for the whole slot
//   ds1..ds3   out  DATA_W  recovered words, held until the next capture
//   dsN_valid  out  1       one-cycle strobe per new word on dsN
//   frame_done out  1       strobe with the valid of the frame's last slot
//   locked     out  1       high while the FSM is in RUN
//   sync_err   out  1       one-cycle strobe on a sync violation
module tdm_demux #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned SAMPLE_OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              frame_sync,
  input  logic [DATA_W-1:0] mux_data,
  output logic [DATA_W-1:0] ds1,
  output logic [DATA_W-1:0] ds2,
  output logic [DATA_W-1:0] ds3,
  output logic              ds1_valid,
  output logic              ds2_valid,
  output logic              ds3_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  // No slot is longer than six cycles, so the offset saturates at 5 before
  // the per-mode clamp.
  localparam logic [2:0] OFF_SAT = (SAMPLE_OFFSET > 5) ? 3'd5 : SAMPLE_OFFSET[2:0];

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt, w_cnt_eff;
  logic [1:0] r_mode_q, w_mode_nxt, w_mode_eff;
  logic       w_cap_en;
  logic [2:0] w_len, w_scyc, w_off;
  logic [1:0] w_slot;
  logic       w_hit;
`ifdef DEMUX_LOCK_CHECK_EN
  logic       w_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mode_q <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode_q <= w_mode_nxt;
    end
  end

  // w_cnt_eff / w_mode_eff describe the position and mode in force for the
  // current cycle: a sync forces position 0, and position 0 samples the new
  // mode, so the slot decode below always sees what this cycle really is.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_eff   = r_cnt;
    w_cnt_nxt   = r_cnt;
    w_mode_eff  = r_mode_q;
    w_mode_nxt  = r_mode_q;
    w_cap_en    = 1'b0;
`ifdef DEMUX_LOCK_CHECK_EN
    w_err       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (frame_sync && (mode != 2'd0)) begin
          w_state_nxt = RUN;
          w_cnt_eff   = '0;
          w_cnt_nxt   = 3'd1;
          w_mode_eff  = mode;
          w_mode_nxt  = mode;
          w_cap_en    = 1'b1;
        end
      end
      RUN: begin
        w_cap_en = 1'b1;
`ifdef DEMUX_LOCK_CHECK_EN
        if (frame_sync && (r_cnt != 3'd0)) begin
          w_err     = 1'b1;
          w_cap_en  = 1'b0;
          w_cnt_eff = '0;
        end else if (!frame_sync && (r_cnt == 3'd0)) begin
          w_err       = 1'b1;
          w_cap_en    = 1'b0;
          w_state_nxt = IDLE;
        end
`else
        if (frame_sync) w_cnt_eff = '0;
`endif
        if ((w_state_nxt == RUN) && (w_cnt_eff == 3'd0)) begin
          if (mode == 2'd0) begin
            w_state_nxt = IDLE;
            w_cap_en    = 1'b0;
          end else begin
            w_mode_eff = mode;
            w_mode_nxt = mode;
          end
        end
        w_cnt_nxt = (w_cnt_eff == 3'd5) ? '0 : w_cnt_eff + 3'd1;
      end
    endcase
  end

  // Slot index / cycle-within-slot for the three legal slot lengths.
  always_comb begin
    w_len  = 3'd6;
    w_slot = 2'd0;
    w_scyc = w_cnt_eff;
    case (w_mode_eff)
      2'd2: begin
        w_len = 3'd3;
        if (w_cnt_eff >= 3'd3) begin
          w_slot = 2'd1;
          w_scyc = w_cnt_eff - 3'd3;
        end
      end
      2'd3: begin
        w_len  = 3'd2;
        w_slot = w_cnt_eff[2:1];
        w_scyc = {2'b00, w_cnt_eff[0]};
      end
      default: ;
    endcase
    w_off = (OFF_SAT >= w_len) ? (w_len - 3'd1) : OFF_SAT;
    w_hit = w_cap_en && (w_scyc == w_off);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds1        <= '0;
      ds2        <= '0;
      ds3        <= '0;
      ds1_valid  <= 1'b0;
      ds2_valid  <= 1'b0;
      ds3_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef DEMUX_LOCK_CHECK_EN
      sync_err   <= 1'b0;
`endif
    end else begin
      ds1_valid  <= 1'b0;
      ds2_valid  <= 1'b0;
      ds3_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef DEMUX_LOCK_CHECK_EN
      sync_err   <= w_err;
`endif
      if (w_hit) begin
        frame_done <= (w_slot == (w_mode_eff - 2'd1));
        case (w_slot)
          2'd0:    begin ds1 <= mux_data; ds1_valid <= 1'b1; end
          2'd1:    begin ds2 <= mux_data; ds2_valid <= 1'b1; end
          default: begin ds3 <= mux_data; ds3_valid <= 1'b1; end
        endcase
      end
    end
  end

`ifndef DEMUX_LOCK_CHECK_EN
  assign sync_err = 1'b0;
`endif

  assign locked = (r_state == RUN);

endmodule
